// File: rtl/lbus_initiator_if.sv
// Request/response and local target bus signals of the local-bus initiator.
// master is the initiator's view; slave is the requester/target side.
interface lbus_initiator_if;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_adr;
    logic [7:0]  req_len;
    logic [3:0]  req_be_n;
    logic [2:0]  req_bar;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  err;
    logic [8:0]  beats_done;
    logic [31:0] s_adr, s_adi, s_ado;
    logic [5:0]  s_barhit;
    logic        s_ebarhit;
    logic [3:0]  s_be_n;
    logic        s_rd, s_wr, s_we, s_nextd;
    logic        s_drdy, s_term, s_abort;

    modport master (
        input  req_valid, req_write, req_adr, req_len, req_be_n, req_bar,
               wd_valid, wd_data, s_ado, s_drdy, s_term, s_abort,
        output req_ready, wd_ready, rd_valid, rd_data, done, err, beats_done,
               s_adr, s_adi, s_barhit, s_ebarhit, s_be_n, s_rd, s_wr, s_we, s_nextd
    );

    modport slave (
        output req_valid, req_write, req_adr, req_len, req_be_n, req_bar,
               wd_valid, wd_data, s_ado, s_drdy, s_term, s_abort,
        input  req_ready, wd_ready, rd_valid, rd_data, done, err, beats_done,
               s_adr, s_adi, s_barhit, s_ebarhit, s_be_n, s_rd, s_wr, s_we, s_nextd
    );
endinterface

// File: rtl/lbus_initiator.sv
// Local target bus initiator: runs single/burst read and write transactions
// against application target logic and reports completion status.
module lbus_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    lbus_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_q;
    logic [31:0] adr_q, rd_data_q;
    logic [7:0]  cnt_q;
    logic [8:0]  beats_q;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  err_q, fin_err;
    logic [5:0]  barhit_q;
    logic [3:0]  be_n_q;
    logic        ebarhit_q, write_q, rd_q, wr_q, done_q, rd_valid_q;
    logic        beat, fin;

    // An abort in the same cycle as s_drdy kills the beat.
    assign beat  = (state_q == DATA) && bus.s_drdy && !bus.s_abort &&
                   (!write_q || bus.wd_valid);
    assign tmo_d = tmo_q + 16'd1;

    always_comb begin
        fin     = 1'b1;
        fin_err = 2'b00;
        if (bus.s_abort)                          fin_err = 2'b01;
        else if (beat && cnt_q == 8'd0)           fin_err = 2'b00;
        else if (bus.s_term)                      fin_err = 2'b11;
        else if (!beat && tmo_d == 16'(TIMEOUT))  fin_err = 2'b10;
        else                                      fin     = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            rd_data_q  <= '0;
            cnt_q      <= '0;
            beats_q    <= '0;
            tmo_q      <= '0;
            err_q      <= '0;
            barhit_q   <= '0;
            be_n_q     <= 4'hF;
            ebarhit_q  <= 1'b0;
            write_q    <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    state_q   <= ADDR;
                    adr_q     <= bus.req_adr;
                    be_n_q    <= bus.req_be_n;
                    write_q   <= bus.req_write;
                    rd_q      <= !bus.req_write;
                    wr_q      <= bus.req_write;
                    barhit_q  <= (bus.req_bar < 3'd6) ? (6'b000001 << bus.req_bar) : 6'd0;
                    ebarhit_q <= (bus.req_bar >= 3'd6);
                    cnt_q     <= bus.req_len;
                    tmo_q     <= '0;
                    beats_q   <= '0;
                    err_q     <= 2'b00;
                end
                ADDR: state_q <= DATA;
                DATA: begin
                    if (beat) begin
                        adr_q      <= adr_q + 32'd4;
                        beats_q    <= beats_q + 9'd1;
                        cnt_q      <= cnt_q - 8'd1;
                        tmo_q      <= '0;
                        rd_valid_q <= !write_q;
                        if (!write_q) rd_data_q <= bus.s_ado;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                    if (fin) begin
                        state_q   <= DONE;
                        err_q     <= fin_err;
                        done_q    <= 1'b1;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        barhit_q  <= '0;
                        ebarhit_q <= 1'b0;
                        be_n_q    <= 4'hF;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.wd_ready   = beat && write_q;
    assign bus.s_we       = beat && write_q;
    assign bus.s_adi      = (beat && write_q) ? bus.wd_data : 32'd0;
    assign bus.s_nextd    = beat;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.beats_done = beats_q;
    assign bus.s_adr      = adr_q;
    assign bus.s_barhit   = barhit_q;
    assign bus.s_ebarhit  = ebarhit_q;
    assign bus.s_be_n     = be_n_q;
    assign bus.s_rd       = rd_q;
    assign bus.s_wr       = wr_q;
endmodule

// File: tb/tb_lbus_initiator.sv
// Bench for lbus_initiator: per-cycle target plans, an end-of-transaction
// reference model over the plan, and directed plus randomized transactions.
module tb_lbus_initiator;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lbus_initiator_if bus();
    lbus_initiator #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    bit          p_drdy[512], p_wdv[512], p_term[512], p_abort[512];
    logic [31:0] p_wdata[512];
    bit          ado_adr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_adr = '0; bus.req_len = '0;
        bus.req_be_n = 4'hF; bus.req_bar = '0; bus.wd_valid = 1'b0; bus.wd_data = '0;
        bus.s_ado = '0; bus.s_drdy = 1'b0; bus.s_term = 1'b0; bus.s_abort = 1'b0;
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 512; k++) begin
            p_drdy[k] = 1'b1; p_wdv[k] = 1'b1; p_term[k] = 1'b0; p_abort[k] = 1'b0;
            p_wdata[k] = $urandom;
        end
        ado_adr = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_beats"}, 32'(bus.beats_done), 32'd0);
        chk({tag, "_s_be_n"}, 32'(bus.s_be_n), 32'hF);
        chk({tag, "_s_rd_wr_we"}, {29'd0, bus.s_rd, bus.s_wr, bus.s_we}, 32'd0);
        chk({tag, "_s_adr"}, bus.s_adr, 32'd0);
        chk({tag, "_bar"}, {25'd0, bus.s_ebarhit, bus.s_barhit}, 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] adr, input int len,
                           input logic [3:0] be, input logic [2:0] bar);
        bit          e_beat[512];
        logic [31:0] ado_k[512];
        logic [31:0] ea;
        logic [6:0]  ebar;
        int e_end = -1, e_err = 0, e_beats = 0, idle = 0, nb = 0, nwe = 0;

        // Expected outcome straight from the plan.
        for (int k = 0; k < 512 && e_end < 0; k++) begin
            e_beat[k] = 1'b0;
            if (p_abort[k]) begin e_end = k; e_err = 1; end
            else if (p_drdy[k] && (!wr || p_wdv[k])) begin
                e_beat[k] = 1'b1; e_beats++; idle = 0;
                if (e_beats == len + 1) begin e_end = k; e_err = 0; end
                else if (p_term[k]) begin e_end = k; e_err = 3; end
            end else if (p_term[k]) begin e_end = k; e_err = 3; end
            else begin
                idle++;
                if (idle == TMO) begin e_end = k; e_err = 2; end
            end
        end
        if (e_end < 0) begin
            errors++;
            $display("FAIL plan_end observed=open expected=closed");
            return;
        end
        ebar = (bar < 3'd6) ? {1'b0, 6'b000001 << bar} : 7'b1000000;

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_adr = adr;
        bus.req_len = 8'(len); bus.req_be_n = be; bus.req_bar = bar;
        #1 chk("accept_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        drive_idle();
        bus.s_drdy = 1'b1; bus.wd_valid = 1'b1;
        #1;
        chk("addr_adr", bus.s_adr, adr);
        chk("addr_bar", {25'd0, bus.s_ebarhit, bus.s_barhit}, {25'd0, ebar});
        chk("addr_be", 32'(bus.s_be_n), 32'(be));
        chk("addr_rdwr", {30'd0, bus.s_rd, bus.s_wr}, {30'd0, !wr, wr});
        chk("addr_idle", {29'd0, bus.req_ready, bus.s_nextd, bus.s_we}, 32'd0);

        for (int k = 0; k <= e_end; k++) begin
            @(negedge clk);
            ea = adr + 32'(4 * nb);
            bus.s_drdy = p_drdy[k]; bus.wd_valid = p_wdv[k]; bus.wd_data = p_wdata[k];
            bus.s_term = p_term[k]; bus.s_abort = p_abort[k];
            ado_k[k] = ado_adr ? ea : $urandom;
            bus.s_ado = ado_k[k];
            #1;
            chk("data_adr", bus.s_adr, ea);
            chk("data_nextd", 32'(bus.s_nextd), 32'(e_beat[k]));
            chk("data_we", {30'd0, bus.s_we, bus.wd_ready}, {30'd0, wr && e_beat[k], wr && e_beat[k]});
            chk("data_adi", bus.s_adi, (wr && e_beat[k]) ? p_wdata[k] : 32'd0);
            chk("data_rdwr", {30'd0, bus.s_rd, bus.s_wr}, {30'd0, !wr, wr});
            chk("data_bar", {25'd0, bus.s_ebarhit, bus.s_barhit}, {25'd0, ebar});
            chk("data_done", 32'(bus.done), 32'd0);
            chk("data_rd_valid", 32'(bus.rd_valid), 32'(k > 0 && !wr && e_beat[k-1]));
            if (k > 0 && !wr && e_beat[k-1]) chk("data_rd_data", bus.rd_data, ado_k[k-1]);
            if (bus.s_we) nwe++;
            if (e_beat[k]) nb++;
        end

        @(negedge clk);
        drive_idle();
        #1;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_err", 32'(bus.err), 32'(e_err));
        chk("done_beats", 32'(bus.beats_done), 32'(e_beats));
        chk("done_rdwr", {30'd0, bus.s_rd, bus.s_wr}, 32'd0);
        chk("done_bar", {25'd0, bus.s_ebarhit, bus.s_barhit}, 32'd0);
        chk("done_rd_valid", 32'(bus.rd_valid), 32'(!wr && e_beat[e_end]));
        if (!wr && e_beat[e_end]) chk("done_rd_data", bus.rd_data, ado_k[e_end]);
        chk("we_count", 32'(nwe), wr ? 32'(e_beats) : 32'd0);

        @(negedge clk);
        #1;
        chk("post_ready", 32'(bus.req_ready), 32'd1);
        chk("post_done", 32'(bus.done), 32'd0);
        chk("post_err_hold", 32'(bus.err), 32'(e_err));
        chk("post_beats_hold", 32'(bus.beats_done), 32'(e_beats));
        chk("post_rd_valid", 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        drive_idle();
        #12;
        check_reset_outs("rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check_reset_outs("idle");

        // Single write, combinational drdy.
        clear_plan(); p_wdata[0] = 32'h1234_5678;
        run_txn(1'b1, 32'h0004_0010, 0, 4'h0, 3'd0);

        // Burst read, drdy one cycle late, data = address.
        clear_plan(); ado_adr = 1'b1; p_drdy[0] = 1'b0;
        run_txn(1'b0, 32'h0000_0100, 3, 4'h0, 3'd2);

        // 4-beat write with gapped write data.
        clear_plan();
        p_wdv[1] = 1'b0; p_wdv[3] = 1'b0;
        run_txn(1'b1, 32'h0004_000C, 3, 4'h3, 3'd1);

        // Abort on beat 2, then term on beat 2.
        clear_plan(); p_abort[1] = 1'b1;
        run_txn(1'b0, 32'h0000_2000, 3, 4'h0, 3'd6);
        clear_plan(); p_term[1] = 1'b1;
        run_txn(1'b0, 32'h0000_3000, 3, 4'h0, 3'd5);

        // Timeout with drdy never raised.
        clear_plan();
        for (int k = 0; k < 512; k++) p_drdy[k] = 1'b0;
        run_txn(1'b0, 32'h0000_4000, 0, 4'h0, 3'd7);

        // Address wrap at the top of the space.
        clear_plan(); ado_adr = 1'b1;
        run_txn(1'b0, 32'hFFFF_FFFC, 1, 4'h0, 3'd3);

        // Randomized transactions.
        for (int t = 0; t < 24; t++) begin
            clear_plan();
            for (int k = 0; k < 512; k++) begin
                p_drdy[k]  = ($urandom_range(3, 0) != 0);
                p_wdv[k]   = ($urandom_range(3, 0) != 0);
                p_term[k]  = ($urandom_range(31, 0) == 0);
                p_abort[k] = ($urandom_range(31, 0) == 0);
            end
            run_txn(1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC,
                    int'($urandom_range(15, 0)), 4'($urandom), 3'($urandom));
        end

        // Reset in the middle of a 256-beat write.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_adr = 32'h0000_8000;
        bus.req_len = 8'd255; bus.req_be_n = 4'h0; bus.req_bar = 3'd0;
        @(negedge clk);
        drive_idle();
        repeat (3) begin
            @(negedge clk);
            bus.s_drdy = 1'b1; bus.wd_valid = 1'b1; bus.wd_data = $urandom;
        end
        #1;
        chk("mid_we", {30'd0, bus.s_wr, bus.s_we}, 32'd3);
        #1 rst = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        repeat (2) begin
            @(negedge clk);
            #1 chk("mid_rst_no_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        #1 check_reset_outs("after_rst");

        // Restart after reset.
        clear_plan(); ado_adr = 1'b1;
        run_txn(1'b0, 32'h0000_0040, 2, 4'h0, 3'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
